lc3_mem_ctrl: RTL
=================

Name: lc3_mem_ctrl

Overview:
Parametrised, multi-cycle memory-access stage for the LC3 pipeline. It generalises the combinational memory-access stage to support:
- all four access modes: LD, LDI, ST, STI;
- a data memory with variable latency, using a handshake;
- a wait-state timeout.
It sits between the execute/control stage (request side) and the data memory (DMem side). It returns load data to writeback and stalls the pipeline while busy.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address width (ADDR_W <= DATA_W so an indirect pointer fits in a word)
WAIT_MAX, 15, max cycles to wait for dmem_ack before timeout; range 1..255

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  2  0=LD, 1=LDI, 2=ST, 3=STI
req_addr  in  ADDR_W  effective/pointer address
req_data  in  DATA_W  store data
dmem_en  out  1  memory access strobe
dmem_rd  out  1  1=read, 0=write
dmem_addr  out  ADDR_W  memory address
dmem_din  out  DATA_W  write data
dmem_dout  in  DATA_W  read data, valid with dmem_ack
dmem_ack  in  1  access complete
resp_valid  out  1  one-cycle completion pulse
resp_data  out  DATA_W  load result (0 for stores and errors)
resp_err  out  1  timeout flag, qualified by resp_valid
busy  out  1  pipeline stall; high in every state except IDLE

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, req_ready=1, dmem_en=0, dmem_rd=1, dmem_addr=0, dmem_din=0, resp_valid=0, resp_data=0, resp_err=0, busy=0, wait counter=0.
- All outputs are registered or decoded from state. Outputs are never high-Z.
- Accept rule: a request is accepted when req_valid && req_ready. On accept, op, addr and data are latched. req_ready = (state==IDLE) and is deasserted the cycle after accept.
- State machine:
  - IDLE: on accept, LD→RD, ST→WR, LDI/STI→PTR.
  - PTR: dmem_en=1, dmem_rd=1, dmem_addr=latched addr. On dmem_ack, capture dmem_dout[ADDR_W-1:0] as the new address, then LDI→RD, STI→WR.
  - RD: dmem_en=1, dmem_rd=1. On dmem_ack, capture dmem_dout into resp_data, then go to RESP.
  - WR: dmem_en=1, dmem_rd=0, dmem_din=latched data. On dmem_ack, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Handshake: dmem_en, dmem_rd, dmem_addr and dmem_din stay stable from entry into an access state until the cycle dmem_ack is sampled high. dmem_en drops in the cycle after ack.
  - Between PTR and RD/WR, dmem_en drops for exactly one cycle.
  - An ack arriving while dmem_en=0 is ignored.
- Latency: minimum accept→resp_valid is 3 cycles for LD/ST (ack in the first access cycle) and 5 cycles for LDI/STI.
- Timeout:
  - The wait counter clears on entry to each access state and increments every cycle without ack.
  - When the counter reaches WAIT_MAX with no ack, abort to RESP with resp_err=1 and resp_data=0. dmem_en deasserts.
  - An ack in the same cycle the counter reaches WAIT_MAX counts as success; ack has priority.
- resp_err and resp_data hold their values until the next accept. resp_err clears on accept.
- Reset mid-operation: returns to IDLE in the next cycle, with dmem_en=0 and no resp_valid. The in-flight request is discarded.
- req_valid while busy is ignored; the requester must hold it until req_ready.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - enum mem_op_e {OP_LD, OP_LDI, OP_ST, OP_STI};
  - enum mem_state_e {IDLE, PTR, RD, WR, RESP};
  - constant DMEM_READ=1'b1.
- One natural sub-module, lc3_mem_wait_timer: a counter with clear, enable and an expired output at WAIT_MAX, sized $clog2(WAIT_MAX+1).

Test Plan:
- LD: req_op=0, req_addr=0x3000, ack after 2 cycles with dout=0x1234 → dmem_addr=0x3000, dmem_rd=1 held for 3 cycles; resp_valid pulse with resp_data=0x1234, resp_err=0.
- ST: req_op=2, addr=0x4000, data=0xBEEF, immediate ack → dmem_rd=0 and dmem_din=0xBEEF for one cycle; resp_valid 3 cycles after accept, resp_data=0.
- LDI: addr=0x3000; first ack dout=0x5000, second ack dout=0x00AA → second access addresses 0x5000 after a one-cycle dmem_en gap; resp_data=0x00AA.
- STI with timeout: WAIT_MAX=4, pointer ack returns 0x6000, no second ack → dmem_en low after 4 wait cycles; resp_valid=1, resp_err=1, resp_data=0; req_ready=1 on the next cycle.
- Reset mid-RD: assert reset during the 2nd wait cycle → all outputs at reset values next cycle, no resp_valid. A new LD then completes normally.
- Back-to-back: hold req_valid with two LDs → the second is accepted only in the cycle after RESP, and no ack-before-en ack is consumed.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and helpers for the LC3 multi-cycle memory-access stage.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'd0,
    OP_LDI = 2'd1,
    OP_ST  = 2'd2,
    OP_STI = 2'd3
  } mem_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PTR,
    RD,
    WR,
    RESP
  } mem_state_e;

  localparam logic DMEM_READ  = 1'b1;
  localparam logic DMEM_WRITE = 1'b0;

  // Indirect ops always start with a pointer fetch.
  function automatic mem_state_e first_state(input mem_op_e op);
    case (op)
      OP_LD:   return RD;
      OP_ST:   return WR;
      default: return PTR;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_ctrl_wait_timer.sv
// Wait-state counter: clears on request, counts while enabled, flags WAIT_MAX.
module lc3_mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int                CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] r_count;

  // Saturates at WAIT_MAX so a late clear can never observe a wrapped count.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX_C)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == MAX_C);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC3 multi-cycle memory-access stage: LD/LDI/ST/STI over an ack handshake,
// with a wait-state timeout that aborts to an error response.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              dmem_en,
  output logic              dmem_rd,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_ack,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);

  mem_state_e        r_state;
  mem_op_e           r_op;
  logic              r_dmem_en;
  logic              r_dmem_rd;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_din;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic w_accept;
  logic w_access;
  logic w_ack;
  logic w_ptr_done;
  logic w_expired;

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_access   = (r_state == PTR) || (r_state == RD) || (r_state == WR);
  // Acks only count while the strobe is up; stray acks are dropped here.
  assign w_ack      = r_dmem_en && dmem_ack;
  assign w_ptr_done = (r_state == PTR) && w_ack;

  lc3_mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_access || w_ptr_done),
    .i_enable  (w_access && !w_ack),
    .o_expired (w_expired)
  );

  // NOTE: reset is synchronous here; all state uses non-blocking assignment.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_op         <= OP_LD;
      r_dmem_en    <= 1'b0;
      r_dmem_rd    <= DMEM_READ;
      r_dmem_addr  <= '0;
      r_dmem_din   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= mem_op_e'(req_op);
            r_dmem_addr <= req_addr;
            r_dmem_din  <= req_data;
            r_dmem_rd   <= (mem_op_e'(req_op) == OP_ST) ? DMEM_WRITE : DMEM_READ;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_state     <= first_state(mem_op_e'(req_op));
          end
        end
        PTR, RD, WR: begin
          // Each access state spends its first cycle with the strobe low.
          if (!r_dmem_en) begin
            r_dmem_en <= 1'b1;
          end else if (dmem_ack) begin
            r_dmem_en <= 1'b0;
            if (r_state == PTR) begin
              r_dmem_addr <= dmem_dout[ADDR_W-1:0];
              r_dmem_rd   <= (r_op == OP_LDI) ? DMEM_READ : DMEM_WRITE;
              r_state     <= (r_op == OP_LDI) ? RD : WR;
            end else begin
              if (r_state == RD) r_resp_data <= dmem_dout;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end
          end else if (w_expired) begin
            r_dmem_en    <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign dmem_en    = r_dmem_en;
  assign dmem_rd    = r_dmem_rd;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_din   = r_dmem_din;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule
